// File: rtl/aes_round_ctrl_if.sv
// Control bundle between the AES round sequencer (master) and the requester/round datapath (slave).
interface aes_round_ctrl_if #(
    parameter int CNT_W = 4
);
    logic             start_valid;
    logic             start_ready;
    logic             data_capture;
    logic             abort;
    logic             state_load;
    logic             sel_init;
    logic             mix_en;
    logic             key_step;
    logic [CNT_W-1:0] round_idx;
    logic [7:0]       rcon;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    modport master (
        input  start_valid, abort, out_ready,
        output start_ready, data_capture, state_load, sel_init, mix_en,
               key_step, round_idx, rcon, out_valid, busy
    );

    modport slave (
        output start_valid, abort, out_ready,
        input  start_ready, data_capture, state_load, sel_init, mix_en,
               key_step, round_idx, rcon, out_valid, busy
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round sequencer; ciphertext valid NUM_ROUNDS+1 edges after accept.
// Backpressure: result held in DONE until out_ready; no new block accepted until then.
module aes_round_ctrl #(
    parameter int NUM_ROUNDS = 10,
    parameter int CNT_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    aes_round_ctrl_if.master  bus
);
    typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_MIX = CNT_W'(NUM_ROUNDS - 1);

    state_t           st, st_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [7:0]       rcon_q, rcon_n;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Acceptance is the only combinational path; it must vanish the instant rst rises.
    assign bus.start_ready  = ~rst & (st == IDLE) & ~bus.abort;
    assign bus.data_capture = bus.start_valid & bus.start_ready;
    assign bus.round_idx    = cnt;
    assign bus.rcon         = rcon_q;

    always_comb begin
        st_n   = st;
        cnt_n  = cnt;
        rcon_n = rcon_q;
        if (bus.abort) begin
            st_n   = IDLE;
            cnt_n  = '0;
            rcon_n = 8'h00;
        end else begin
            case (st)
                IDLE: begin
                    if (bus.data_capture) st_n = INIT;
                end
                INIT: begin
                    st_n   = ROUND;
                    cnt_n  = CNT_W'(1);
                    rcon_n = 8'h01;
                end
                ROUND: begin
                    cnt_n  = cnt + CNT_W'(1);
                    rcon_n = xtime(rcon_q);
                    if (cnt == LAST_MIX) st_n = FINAL;
                end
                FINAL: begin
                    st_n   = DONE;
                    rcon_n = 8'h00;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        st_n  = IDLE;
                        cnt_n = '0;
                    end
                end
                default: begin
                    st_n   = IDLE;
                    cnt_n  = '0;
                    rcon_n = 8'h00;
                end
            endcase
        end
    end

    // Control outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st             <= IDLE;
            cnt            <= '0;
            rcon_q         <= 8'h00;
            bus.state_load <= 1'b0;
            bus.sel_init   <= 1'b0;
            bus.mix_en     <= 1'b0;
            bus.key_step   <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            st             <= st_n;
            cnt            <= cnt_n;
            rcon_q         <= rcon_n;
            bus.state_load <= (st_n == INIT) || (st_n == ROUND) || (st_n == FINAL);
            bus.sel_init   <= (st_n == INIT);
            bus.mix_en     <= (st_n == ROUND);
            bus.key_step   <= (st_n == ROUND) || (st_n == FINAL);
            bus.out_valid  <= (st_n == DONE);
            bus.busy       <= (st_n != IDLE);
        end
    end
endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench: two sequencers (10 and 4 rounds) driven in lockstep against a phase-count reference model.
module tb_aes_round_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sv  = 1'b0;
    logic ab  = 1'b0;
    logic rdy = 1'b1;

    always #5 clk = ~clk;

    aes_round_ctrl_if #(.CNT_W(4)) ifa();
    aes_round_ctrl_if #(.CNT_W(4)) ifb();

    assign ifa.start_valid = sv;
    assign ifa.abort       = ab;
    assign ifa.out_ready   = rdy;
    assign ifb.start_valid = sv;
    assign ifb.abort       = ab;
    assign ifb.out_ready   = rdy;

    aes_round_ctrl #(.NUM_ROUNDS(10), .CNT_W(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa.master));
    aes_round_ctrl #(.NUM_ROUNDS(4),  .CNT_W(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb.master));

    // {start_ready, data_capture, state_load, sel_init, mix_en, key_step, out_valid, busy, round_idx, rcon}
    wire [19:0] oa = {ifa.start_ready, ifa.data_capture, ifa.state_load, ifa.sel_init, ifa.mix_en,
                      ifa.key_step, ifa.out_valid, ifa.busy, ifa.round_idx, ifa.rcon};
    wire [19:0] ob = {ifb.start_ready, ifb.data_capture, ifb.state_load, ifb.sel_init, ifb.mix_en,
                      ifb.key_step, ifb.out_valid, ifb.busy, ifb.round_idx, ifb.rcon};

    logic [7:0] rc_tbl [10];
    int n_pass = 0;
    int n_tot  = 0;
    int ph_a = 0, ph_b = 0;
    int cyc_n = 0, last_a = -1, last_b = -1, ivs_a = 0, ivs_b = 0;
    bit iv_chk = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Phase 0 = idle, 1 = initial key add, 2..nr+1 = round ph-1, nr+2 = waiting for out_ready.
    function automatic logic [19:0] model_out(input int ph, input int nr, input logic s, input logic a);
        logic [19:0] e;
        int r;
        e = '0;
        if (ph == 0) begin
            e[19] = !a;
            e[18] = s && !a;
        end else if (ph == 1) begin
            e[17] = 1'b1;
            e[16] = 1'b1;
            e[12] = 1'b1;
        end else if (ph <= nr + 1) begin
            r        = ph - 1;
            e[17]    = 1'b1;
            e[15]    = (r < nr);
            e[14]    = 1'b1;
            e[12]    = 1'b1;
            e[11:8]  = 4'(r);
            e[7:0]   = rc_tbl[r-1];
        end else begin
            e[13]   = 1'b1;
            e[12]   = 1'b1;
            e[11:8] = 4'(nr);
        end
        return e;
    endfunction

    function automatic int next_ph(input int ph, input int nr, input logic s, input logic a, input logic r);
        if (a) return 0;
        if (ph == 0) return s ? 1 : 0;
        if (ph <= nr + 1) return ph + 1;
        return r ? 0 : ph;
    endfunction

    task automatic cyc();
        @(negedge clk);
        check("a_outputs", 32'(oa), 32'(model_out(ph_a, 10, sv, ab)));
        check("b_outputs", 32'(ob), 32'(model_out(ph_b, 4, sv, ab)));
        if (iv_chk) begin
            if (oa[18]) begin
                if (last_a >= 0) begin
                    check("a_accept_interval", cyc_n - last_a, 13);
                    ivs_a++;
                end
                last_a = cyc_n;
            end
            if (ob[18]) begin
                if (last_b >= 0) begin
                    check("b_accept_interval", cyc_n - last_b, 7);
                    ivs_b++;
                end
                last_b = cyc_n;
            end
        end
        ph_a = next_ph(ph_a, 10, sv, ab, rdy);
        ph_b = next_ph(ph_b, 4, sv, ab, rdy);
        cyc_n++;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ph(input string tag, input int target);
        int n;
        n = 0;
        while (ph_a != target && n < 60) begin
            cyc();
            n++;
        end
        check(tag, 32'(n < 60), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((ph_a != 0 || ph_b != 0) && n < 60) begin
            cyc();
            n++;
        end
        check(tag, 32'(n < 60), 32'd1);
    endtask

    initial begin
        rc_tbl = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

        // Reset held: every output low, start_ready included.
        #3;
        check("a_reset_outputs", 32'(oa), 32'd0);
        check("b_reset_outputs", 32'(ob), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc();

        // Single request with out_ready high: full round/rcon sequence.
        sv = 1'b1;
        cyc();
        sv = 1'b0;
        wait_idle("wait_first_done");

        // Consumer stalls 5 cycles in DONE.
        sv = 1'b1;
        cyc();
        sv  = 1'b0;
        rdy = 1'b0;
        wait_ph("wait_done_stall", 12);
        repeat (5) cyc();
        check("a_stall_out_valid", 32'(ifa.out_valid), 32'd1);
        rdy = 1'b1;
        cyc();
        check("a_released_busy", 32'(ifa.busy), 32'd0);
        cyc();

        // Back-to-back requests: accept spacing NUM_ROUNDS+3.
        iv_chk = 1'b1;
        sv     = 1'b1;
        repeat (45) cyc();
        iv_chk = 1'b0;
        sv     = 1'b0;
        check("a_interval_count", ivs_a, 3);
        check("b_interval_count", ivs_b, 6);
        wait_idle("wait_b2b_done");

        // Abort during round 5, then abort in idle, then a clean request.
        sv = 1'b1;
        cyc();
        sv = 1'b0;
        wait_ph("wait_round5", 6);
        check("a_round5_idx", 32'(ifa.round_idx), 32'd5);
        ab = 1'b1;
        cyc();
        ab = 1'b0;
        check("a_abort_idx", 32'(ifa.round_idx), 32'd0);
        check("a_abort_rcon", 32'(ifa.rcon), 32'd0);
        wait_idle("wait_after_abort");
        sv = 1'b1;
        ab = 1'b1;
        cyc();
        ab = 1'b0;
        cyc();
        sv = 1'b0;
        wait_idle("wait_post_abort_run");

        // Asynchronous reset in round 7.
        sv = 1'b1;
        cyc();
        sv = 1'b0;
        wait_ph("wait_round7", 8);
        check("a_round7_idx", 32'(ifa.round_idx), 32'd7);
        #2;
        rst = 1'b1;
        #1;
        check("a_async_rst_outputs", 32'(oa), 32'd0);
        check("b_async_rst_outputs", 32'(ob), 32'd0);
        @(posedge clk);
        #1;
        check("a_rst_held_outputs", 32'(oa), 32'd0);
        #2;
        rst  = 1'b0;
        ph_a = 0;
        ph_b = 0;
        cyc();
        sv = 1'b1;
        cyc();
        sv = 1'b0;
        wait_idle("wait_post_rst_run");

        // Random traffic including occasional aborts and consumer stalls.
        repeat (800) begin
            sv  = 1'($urandom_range(0, 1));
            rdy = ($urandom_range(0, 3) != 0);
            ab  = ($urandom_range(0, 39) == 0);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Iterative AES-128 encryption sequencer: owns the round FSM and round counter, and drives the control lines of the single-round datapath (state register, SubBytes/ShiftRows/MixColumns/AddRoundKey chain, on-the-fly key schedule).
- Accepts one block request via valid/ready and steps the datapath through the initial AddRoundKey plus NUM_ROUNDS rounds.
- Presents the result with a valid/ready output handshake. It contains no data bytes itself.

Parameters:
- NUM_ROUNDS, 10: total rounds after initial AddRoundKey; legal range 2..15.
- CNT_W, 4: round counter / round_idx width; must satisfy 2^CNT_W > NUM_ROUNDS.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_valid  in  1  requester has a block (plaintext+key) on datapath inputs.
- start_ready  out  1  controller can accept a block.
- data_capture  out  1  combinational; start_valid & start_ready. Datapath latches plaintext and cipher key on this edge.
- abort  in  1  synchronous cancel of the operation in flight.
- state_load  out  1  datapath state register and round-key register load enable.
- sel_init  out  1  1: state <= captured plaintext ^ cipher key, and key register <= cipher key. 0: state <= round output.
- mix_en  out  1  1: round includes MixColumns; 0: bypass (final round).
- key_step  out  1  1: key register <= next round key, using rcon.
- round_idx  out  CNT_W  current round number, 0 = initial AddRoundKey.
- rcon  out  8  round constant for key expansion this cycle.
- out_valid  out  1  ciphertext in datapath state register is final.
- out_ready  in  1  consumer accepts ciphertext.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, INIT, ROUND, FINAL, DONE. State and counter registers reset asynchronously to IDLE / 0.
- Reset values:
  - All outputs are 0 while rst is high, including start_ready, which is gated by !rst.
  - After reset release, start_ready=1.
- Output decoding: outputs are decoded from registered state (Moore), except data_capture.
- IDLE:
  - start_ready=1; all other outputs 0.
  - data_capture=1 → INIT at the next edge.
- INIT (one cycle):
  - state_load=1, sel_init=1, round_idx=0, rcon=0x00, key_step=0, mix_en=0.
  - → ROUND with round_idx=1.
- ROUND (rounds 1..NUM_ROUNDS-1, one cycle each):
  - state_load=1, mix_en=1, key_step=1.
  - Counter increments each edge.
  - When round_idx==NUM_ROUNDS-1 → FINAL.
- FINAL (one cycle):
  - state_load=1, key_step=1, mix_en=0, round_idx=NUM_ROUNDS.
  - → DONE.
- DONE:
  - out_valid=1, state_load=0; round_idx holds NUM_ROUNDS; rcon=0.
  - out_valid & out_ready → IDLE at the next edge.
  - out_valid is held stable until accepted, regardless of out_ready.
- rcon:
  - Register set to 0x01 on entry to round 1.
  - At each subsequent round advance: rcon <= xtime(rcon), i.e. (rcon<<1) ^ (rcon[7] ? 0x1B : 0x00).
  - Driven onto the port only in ROUND/FINAL; otherwise 0x00.
  - Sequence for NUM_ROUNDS=10: 01,02,04,08,10,20,40,80,1B,36.
- Latency:
  - Accepting edge E0; INIT load at E1; round r load at E(1+r).
  - out_valid rises after edge E(NUM_ROUNDS+1), i.e. after E11 at default.
- Throughput:
  - start_ready is low from E0 until DONE handshake.
  - With out_ready tied 1, minimum accept-to-accept interval is NUM_ROUNDS+3 edges (13 at default).
- abort:
  - Sampled every edge; highest priority after rst.
  - In any non-IDLE state → IDLE next edge; counter and rcon cleared; out_valid drops and no output handshake occurs.
  - In IDLE, abort blocks acceptance that cycle: data_capture is forced 0 and start_ready is 0.
- start_valid outside IDLE is ignored; no queuing.
- Asynchronous rst mid-operation: immediate return to IDLE, all outputs 0; no partial result is presented afterwards.

Test Plan:
- Reset, then start_valid=1 at edge 0 with out_ready=1:
  - data_capture pulses once.
  - INIT at cycle 1 (sel_init=1).
  - round_idx 1..10 on cycles 2..11; mix_en=1 on cycles 2..10, 0 on cycle 11.
  - out_valid high on cycle 12 for exactly one cycle.
- Same run, sampling rcon each cycle of rounds 1..10 → 01,02,04,08,10,20,40,80,1B,36. rcon=00 in INIT, IDLE and DONE.
- out_ready=0 for 5 cycles after out_valid rises:
  - out_valid stays 1, state_load=0, busy=1, start_ready=0 throughout.
  - Raising out_ready → IDLE next edge.
- start_valid held high continuously with out_ready=1 → data_capture pulses exactly 13 cycles apart. No accept while busy=1.
- abort=1 during round_idx=5:
  - Next cycle IDLE, busy=0, round_idx=0, rcon=0; out_valid never asserts.
  - A new request afterwards produces the full 01..36 rcon sequence.
- rst asserted asynchronously mid-round 7:
  - All outputs 0 immediately, without waiting for a clock edge.
  - After release, start_ready=1 and a new request completes normally.
- NUM_ROUNDS=4 → rounds 1..4; FINAL at round_idx=4; out_valid after E5; rcon 01,02,04,08.
